bit_serial_addsub_311: RTL and testbench



---
 rtl/bit_serial_addsub_311.sv | 149 ++++++++++++++
 tb/tb_bit_serial_addsub_311.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/bit_serial_addsub_311.sv
// bit_serial_addsub_311: bit-serial adder/subtractor built around one time-shared 1-bit full adder.
// Latency: start accepted at edge k -> done_311 high in the cycle after edge k+WIDTH; throughput one op per WIDTH+2 cycles.
// Backpressure: none; start_311 is ignored while busy_311 is high (SHIFT/DONE) and is taken again in the next IDLE cycle.
//
// Ports:
//   clk_311     rising-edge clock for all state
//   rst_n_311   synchronous active-low reset
//   start_311   begin an operation (accepted only in IDLE)
//   sub_311     0 = a+b, 1 = a-b (sampled with start_311)
//   a_311/b_311 WIDTH-bit operands (sampled with start_311)
//   busy_311    high in SHIFT and DONE
//   done_311    single-cycle completion pulse
//   result_311  registered sum/difference, held until the next completion
//   cout_311    final carry (for subtract, 1 = no borrow)
//   ovf_311     signed overflow; real logic only when ADDSUB_OVF_EN is defined, otherwise constant 0
//
// Optional feature macro: ADDSUB_OVF_EN (signed overflow flag).

module bit_serial_addsub_311 #(
  parameter int WIDTH = 8
) (
  input  logic             clk_311,
  input  logic             rst_n_311,
  input  logic             start_311,
  input  logic             sub_311,
  input  logic [WIDTH-1:0] a_311,
  input  logic [WIDTH-1:0] b_311,
  output logic             busy_311,
  output logic             done_311,
  output logic [WIDTH-1:0] result_311,
  output logic             cout_311,
  output logic             ovf_311
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] part;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic sum_bit;
  logic cy;

  // The single shared full adder, fed by the LSBs of the operand shift registers.
  assign sum_bit = a_sr[0] ^ b_sr[0] ^ carry;
  assign cy      = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);

  always_ff @(posedge clk_311) begin
    if (!rst_n_311) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy_311  = 1'b0;
    done_311  = 1'b0;
    case (state)
      IDLE: begin
        if (start_311) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy_311 = 1'b1;
        if (cnt == LAST) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        busy_311  = 1'b1;
        done_311  = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_311) begin
    if (!rst_n_311) begin
      a_sr       <= '0;
      b_sr       <= '0;
      part       <= '0;
      carry      <= 1'b0;
      cnt        <= '0;
      result_311 <= '0;
      cout_311   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_311) begin
            // Subtract is a + ~b + 1: invert B here and seed the carry with 1.
            a_sr  <= a_311;
            b_sr  <= b_311 ^ {WIDTH{sub_311}};
            carry <= sub_311;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          part  <= {sum_bit, part[WIDTH-1:1]};
          carry <= cy;
          if (cnt == LAST) begin
            // The final sum bit is produced this cycle, so fold it in directly.
            result_311 <= {sum_bit, part[WIDTH-1:1]};
            cout_311   <= cy;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ADDSUB_OVF_EN
  logic ovf_q;

  // In the last SHIFT cycle the carry register holds the carry into the MSB stage.
  always_ff @(posedge clk_311) begin
    if (!rst_n_311) begin
      ovf_q <= 1'b0;
    end else if (state == SHIFT && cnt == LAST) begin
      ovf_q <= carry ^ cy;
    end
  end

  assign ovf_311 = ovf_q;
`else
  assign ovf_311 = 1'b0;
`endif

endmodule

// File: tb/tb_bit_serial_addsub_311.sv
// tb_bit_serial_addsub_311: directed self-checking bench for bit_serial_addsub_311 at WIDTH=8.
// Latency: inputs driven 1 time unit after a rising edge, outputs sampled at the same point.
// Backpressure: n/a (bench drives start_311 and observes busy_311/done_311 only).

module tb_bit_serial_addsub_311;

  localparam int W = 8;

`ifdef ADDSUB_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic         clk_311;
  logic         rst_n_311;
  logic         start_311;
  logic         sub_311;
  logic [W-1:0] a_311;
  logic [W-1:0] b_311;
  logic         busy_311;
  logic         done_311;
  logic [W-1:0] result_311;
  logic         cout_311;
  logic         ovf_311;

  int errors = 0;
  int checks = 0;

  bit_serial_addsub_311 #(.WIDTH(W)) dut (
    .clk_311    (clk_311),
    .rst_n_311  (rst_n_311),
    .start_311  (start_311),
    .sub_311    (sub_311),
    .a_311      (a_311),
    .b_311      (b_311),
    .busy_311   (busy_311),
    .done_311   (done_311),
    .result_311 (result_311),
    .cout_311   (cout_311),
    .ovf_311    (ovf_311)
  );

  initial clk_311 = 1'b0;
  always #5 clk_311 = ~clk_311;

  task automatic tick;
    @(posedge clk_311);
    #1;
  endtask

  task automatic test_reset;
    rst_n_311 = 1'b0;
    start_311 = 1'b1;  // reset must win over start
    sub_311   = 1'b0;
    a_311     = 8'h12;
    b_311     = 8'h34;
    tick;
    tick;
    checks++; if (busy_311 !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy_311); end
    checks++; if (done_311 !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done_311); end
    checks++; if (result_311 !== 8'h00) begin errors++; $display("FAIL reset_result got=%h want=00", result_311); end
    checks++; if (cout_311 !== 1'b0) begin errors++; $display("FAIL reset_cout got=%b want=0", cout_311); end
    checks++; if (ovf_311 !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b want=0", ovf_311); end
    start_311 = 1'b0;
    rst_n_311 = 1'b1;
    tick;
    checks++; if (busy_311 !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got=%b want=0", busy_311); end
  endtask

  // One operation; operands are scrambled right after acceptance to show they are not re-sampled.
  // Latency is counted in edges after the accepting edge: done must first appear after edge k+W.
  task automatic run_op(input string name, input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] er, input logic ec, input logic ev);
    int lat;
    bit seen;
    a_311 = a; b_311 = b; sub_311 = s; start_311 = 1'b1;
    tick;
    start_311 = 1'b0;
    a_311 = 8'hA5; b_311 = 8'h5A; sub_311 = ~s;
    lat = 0; seen = 1'b0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      tick;
      if (done_311) begin seen = 1'b1; lat = i; end
    end
    checks++; if (lat != W) begin errors++; $display("FAIL %s_latency got=%0d want=%0d (0 = timeout)", name, lat, W); end
    checks++; if (result_311 !== er) begin errors++; $display("FAIL %s_result got=%h want=%h", name, result_311, er); end
    checks++; if (cout_311 !== ec) begin errors++; $display("FAIL %s_cout got=%b want=%b", name, cout_311, ec); end
    checks++; if (ovf_311 !== (ev & OVF_ON)) begin errors++; $display("FAIL %s_ovf got=%b want=%b", name, ovf_311, ev & OVF_ON); end
    checks++; if (busy_311 !== 1'b1) begin errors++; $display("FAIL %s_busy_in_done got=%b want=1", name, busy_311); end
    tick;
    checks++; if (done_311 !== 1'b0 || busy_311 !== 1'b0) begin errors++; $display("FAIL %s_after_done done=%b busy=%b want 0/0", name, done_311, busy_311); end
    checks++; if (result_311 !== er) begin errors++; $display("FAIL %s_result_hold got=%h want=%h", name, result_311, er); end
  endtask

  task automatic test_addsub;
    run_op("add_35_4a", 1'b0, 8'h35, 8'h4A, 8'h7F, 1'b0, 1'b0);
    run_op("add_ff_01", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
    run_op("sub_10_20", 1'b1, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0);
    run_op("sub_20_10", 1'b1, 8'h20, 8'h10, 8'h10, 1'b1, 1'b0);
    run_op("add_7f_01", 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
    run_op("sub_80_01", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1);
  endtask

  // Start pulses during SHIFT (3rd cycle) and during DONE must be ignored.
  task automatic test_ignore_start;
    int busy_cnt;
    int done_cnt;
    a_311 = 8'h35; b_311 = 8'h4A; sub_311 = 1'b0; start_311 = 1'b1;
    tick;
    busy_cnt = busy_311 ? 1 : 0;
    done_cnt = 0;
    for (int i = 1; i <= 12; i++) begin
      start_311 = (i == 3) || done_311;
      a_311 = 8'hFF; b_311 = 8'hFF; sub_311 = 1'b1;
      tick;
      if (busy_311) busy_cnt++;
      if (done_311) done_cnt++;
    end
    start_311 = 1'b0;
    checks++; if (busy_cnt != W + 1) begin errors++; $display("FAIL ignore_busy_len got=%0d want=%0d", busy_cnt, W + 1); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL ignore_done_count got=%0d want=1", done_cnt); end
    checks++; if (result_311 !== 8'h7F) begin errors++; $display("FAIL ignore_result got=%h want=7f", result_311); end
  endtask

  // Start held high across DONE is taken in the next IDLE; done-to-done spacing is W+2 edges.
  task automatic test_back_to_back;
    int first;
    int second;
    int ndone;
    logic [W-1:0] r1;
    r1 = 8'h00;
    first = 0; second = 0; ndone = 0;
    a_311 = 8'h20; b_311 = 8'h10; sub_311 = 1'b1; start_311 = 1'b1;
    tick;
    a_311 = 8'h35; b_311 = 8'h4A; sub_311 = 1'b0;
    for (int i = 1; i <= 30 && ndone < 2; i++) begin
      tick;
      if (done_311) begin
        ndone++;
        if (ndone == 1) begin first = i; r1 = result_311; end
        else begin second = i; start_311 = 1'b0; end
      end
    end
    start_311 = 1'b0;
    checks++; if (r1 !== 8'h10) begin errors++; $display("FAIL b2b_first_result got=%h want=10", r1); end
    checks++; if (result_311 !== 8'h7F) begin errors++; $display("FAIL b2b_second_result got=%h want=7f", result_311); end
    checks++; if (second - first != W + 2) begin errors++; $display("FAIL b2b_spacing got=%0d want=%0d", second - first, W + 2); end
    tick;
    tick;
  endtask

  // Reset at the 4th SHIFT cycle aborts with no done pulse and clears the outputs.
  task automatic test_abort;
    int done_cnt;
    run_op("pre_abort", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1);
    a_311 = 8'h35; b_311 = 8'h4A; sub_311 = 1'b0; start_311 = 1'b1;
    tick;
    start_311 = 1'b0;
    tick; tick; tick;
    rst_n_311 = 1'b0;
    tick;
    rst_n_311 = 1'b1;
    checks++; if (busy_311 !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b want=0", busy_311); end
    checks++; if (result_311 !== 8'h00 || cout_311 !== 1'b0 || ovf_311 !== 1'b0) begin
      errors++; $display("FAIL abort_outputs result=%h cout=%b ovf=%b want 00/0/0", result_311, cout_311, ovf_311);
    end
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick;
      if (done_311) done_cnt++;
    end
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL abort_no_done got=%0d want=0", done_cnt); end
    checks++; if (result_311 !== 8'h00) begin errors++; $display("FAIL abort_result_stays got=%h want=00", result_311); end
    run_op("post_abort", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
  endtask

  initial begin
    rst_n_311 = 1'b0;
    start_311 = 1'b0;
    sub_311   = 1'b0;
    a_311     = '0;
    b_311     = '0;
    test_reset;
    test_addsub;
    test_ignore_start;
    test_back_to_back;
    test_abort;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
